range_seq_sender: RTL and testbench
===================================

# range_seq_sender

Initiator side of the go/finish sample-stream protocol. The block buffers up to DEPTH samples written by a host, then on `start` replays them as one contiguous sequence. The first sample goes out with `go`, the last with `finish`, and the samples in between go out one per cycle. Its outputs drive a range-computing receiver directly, and it is the standard stimulus source for that receiver in subsystem benches.

## Interface
- WIDTH, 16, sample width in bits
- DEPTH, 8, buffer capacity in samples (≥2, power of two)
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  reset, synchronous, active-high
- wr_data  input  WIDTH  sample to append to buffer
- wr_en  input  1  append wr_data this cycle
- start  input  1  begin transmitting buffered sequence
- full  output  1  buffer holds DEPTH samples
- count  output  $clog2(DEPTH+1)  samples currently buffered
- busy  output  1  sequence transmission in progress
- done  output  1  one-cycle pulse after finish cycle
- error  output  1  one-cycle pulse flagging a rejected request
- data_out  output  WIDTH  sample on the protocol bus
- go  output  1  marks first sample of sequence
- finish  output  1  marks last sample of sequence

## Operation
- **Protocol definition:**
  - `go` is high for exactly one cycle, with the first sample on `data_out`.
  - After that, one sample per cycle with no gaps.
  - `finish` is high for exactly one cycle, with the last sample.
  - `go` and `finish` are never high in the same cycle.
  - `data_out` is 0 whenever no sample is being sent.
- **FSM states:** IDLE, GO, BODY, FIN, DONE.
- **IDLE:**
  - `wr_en` with `!full` pushes `wr_data` and increments `count`.
  - `wr_en` with `full` is dropped and pulses `error`.
- **Start transitions:**
  - `start` with `count`≥1 goes to GO and latches N=`count`.
  - `start` with `count`=0 stays in IDLE and pulses `error`.
- **Start/write collision:** `start` and `wr_en` in the same IDLE cycle means `start` wins. The write is dropped, `error` pulses, and N excludes that write.
- **GO:** pops the head, drives `go`=1 and `data_out`=head.
  - N=1: next state is FIN, which resends the same sample with `finish`, so the receiver sees range 0.
  - N=2: next state is FIN.
  - N>2: next state is BODY.
- **BODY:** pops and drives one sample per cycle for N−2 cycles, then goes to FIN.
- **FIN:** drives the last sample with `finish`=1, then goes to DONE.
- **DONE:** `done`=1, `busy`=0, then returns to IDLE.
- **During GO/BODY/FIN:**
  - `busy`=1.
  - `wr_en` is dropped and pulses `error`.
  - `start` is ignored with no error.
- **End state:** the buffer is empty (`count`=0) after every completed sequence.
- **Width rule:** `count` is a pure occupancy counter of $clog2(DEPTH+1) bits. FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- **Outputs:** all outputs are registered.
- **Reset values:** `full`, `count`, `busy`, `done`, `error`, `data_out`, `go`, `finish` are all 0. The FIFO is emptied and the FSM is in IDLE.
- **Start latency:** `start` sampled at edge T gives `go` at cycle T+1.
- **Finish timing:**
  - N≥2: `finish` at cycle T+N.
  - N=1: `finish` at T+2.
- **Done timing:** `done` comes one cycle after `finish`. `busy` is high from T+1 through the `finish` cycle inclusive.
- **Error timing:** `error` is asserted in the cycle after the offending request.
- **Write timing:** a write accepted at edge T is visible in `count`/`full` at T+1.
- **Back-to-back:** a new `start` is accepted in the cycle `done` is high, because the FSM is then leaving DONE for IDLE. Minimum gap between sequences is two idle bus cycles.
- **Reset mid-sequence:**
  - All outputs are 0 on the next cycle.
  - No `finish` or `done` is emitted.
  - Remaining samples are discarded.

## Structure
- **Package `range_seq_pkg`:**
  - `state_t` enum {IDLE, GO, BODY, FIN, DONE}.
  - Default WIDTH/DEPTH localparams.
- **Sub-module `sample_fifo`:**
  - Parameterized WIDTH/DEPTH.
  - Ports: push, pop, data in/out, `count`, `full`, empty.
  - Synchronous reset.
- **Top level:** the FSM, N/remaining-count register, and output registers.

## Test plan
- Write 5, 9, 2, 7 then `start`:
  - `go` with 5 at T+1.
  - Then 9, 2.
  - `finish` with 7 at T+4.
  - `done` at T+5, `count`=0.
- Write single 42 then `start`: `go`/42 at T+1, `finish`/42 at T+2, never coincident.
- Fill 8 samples, 9th write:
  - `error` pulse.
  - `count` stays 8, `full`=1.
  - The following sequence emits exactly the 8 samples in order.
- `start` with empty buffer gives an `error` pulse, with no `go` and `busy`=0. Write during BODY gives an `error` pulse and the written sample is not sent.
- Assert `reset` during BODY of a 6-sample sequence:
  - All outputs are 0 next cycle.
  - No `finish`.
  - `count`=0.
- Same-cycle `start`+`wr_en` with 3 buffered: `error` pulse, exactly 3 samples sent. A `start` in the `done` cycle after a refill produces `go` two cycles later.

Source files
------------

// File: rtl/range_seq_pkg.sv
// Shared types and default sizing for the go/finish sample-stream sender.
package range_seq_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultDepth = 8;

    typedef enum logic [2:0] {
        StIdle,
        StGo,
        StBody,
        StFin,
        StDone
    } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous-reset sample buffer with an occupancy counter and registered full flag.
module sample_fifo
    import range_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AddrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             full_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers are power-of-two wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AddrW'(1);
            if (do_pop)  rptr_q <= rptr_q + AddrW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CntW'(DEPTH));
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/range_seq_sender.sv
// Buffers host samples, then replays them as one go ... finish sequence on the protocol bus.
module range_seq_sender
    import range_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       wr_en_i,
    input  logic                       start_i,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       error_o,
    output logic [WIDTH-1:0]           data_out_o,
    output logic                       go_o,
    output logic                       finish_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    state_t           state_q, state_d;
    logic [CntW-1:0]  rem_q, rem_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             go_q, go_d, finish_q, finish_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;

    logic             push, pop, start_eff;
    logic [WIDTH-1:0] head;
    logic [CntW-1:0]  fifo_count;
    logic             fifo_full, fifo_empty;

    sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (wr_data_i),
        .data_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A start seen in the DONE cycle is held over and acted on in the following IDLE cycle.
    assign start_eff = start_i || pend_q;

    always_ff @(posedge clock) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_eff && !fifo_empty) state_d = StGo;
            StGo:    state_d = (rem_q <= CntW'(1)) ? StFin : StBody;
            StBody:  if (rem_q == CntW'(1)) state_d = StFin;
            StFin:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // rem_q counts samples still in the buffer after the one currently on the bus.
    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        rem_d    = rem_q;
        pend_d   = 1'b0;
        data_d   = '0;
        go_d     = 1'b0;
        finish_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        error_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_eff) begin
                    error_d = wr_en_i || fifo_empty;
                    if (!fifo_empty) begin
                        pop    = 1'b1;
                        data_d = head;
                        go_d   = 1'b1;
                        busy_d = 1'b1;
                        rem_d  = fifo_count - CntW'(1);
                    end
                end else if (wr_en_i) begin
                    error_d = fifo_full;
                    push    = !fifo_full;
                end
            end
            StGo, StBody: begin
                busy_d  = 1'b1;
                error_d = wr_en_i;
                if (rem_q == '0) begin
                    // Single-sample sequence: resend it so the receiver sees a zero range.
                    data_d   = data_q;
                    finish_d = 1'b1;
                end else begin
                    pop      = 1'b1;
                    data_d   = head;
                    rem_d    = rem_q - CntW'(1);
                    finish_d = (rem_q == CntW'(1));
                end
            end
            StFin: begin
                done_d  = 1'b1;
                error_d = wr_en_i;
            end
            StDone: begin
                pend_d  = start_i;
                error_d = wr_en_i && fifo_full;
                push    = wr_en_i && !fifo_full;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q    <= '0;
            pend_q   <= 1'b0;
            data_q   <= '0;
            go_q     <= 1'b0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            pend_q   <= pend_d;
            data_q   <= data_d;
            go_q     <= go_d;
            finish_q <= finish_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign full_o     = fifo_full;
    assign count_o    = fifo_count;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign data_out_o = data_q;
    assign go_o       = go_q;
    assign finish_o   = finish_q;

endmodule

// File: tb/tb_range_seq_sender.sv
// Directed bench for range_seq_sender with a sample scoreboard.
module tb_range_seq_sender;

    logic        clock;
    logic        reset;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        start;
    logic        full;
    logic [3:0]  count;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] data_out;
    logic        go;
    logic        finish;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] sb[$];

    range_seq_sender #(
        .WIDTH (16),
        .DEPTH (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_data_i  (wr_data),
        .wr_en_i    (wr_en),
        .start_i    (start),
        .full_o     (full),
        .count_o    (count),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error),
        .data_out_o (data_out),
        .go_o       (go),
        .finish_o   (finish)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [15:0] v, input bit accept);
        wr_en   = 1'b1;
        wr_data = v;
        tick();
        wr_en   = 1'b0;
        if (accept) sb.push_back(v);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".go"}, go, 0);
        check({tag, ".finish"}, finish, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".data"}, data_out, 0);
    endtask

    // Entered in the go cycle; returns in the done cycle. Scoreboard supplies every sample.
    task automatic observe(input int inject, input bit err_first);
        int n;
        int len;
        logic [15:0] exp_d;
        n   = sb.size();
        len = (n < 2) ? 2 : n;
        exp_d = '0;
        for (int k = 1; k <= len; k++) begin
            if (k <= n) exp_d = sb.pop_front();
            check($sformatf("seq%0d.go", k), go, (k == 1));
            check($sformatf("seq%0d.finish", k), finish, (k == len));
            check($sformatf("seq%0d.busy", k), busy, 1);
            check($sformatf("seq%0d.data", k), data_out, exp_d);
            check($sformatf("seq%0d.error", k), error,
                  (k == 1) ? err_first : ((k - 1) == inject));
            wr_en   = (k == inject);
            wr_data = 16'hBEEF;
            tick();
            wr_en = 1'b0;
        end
        check("done.pulse", done, 1);
        check_idle_outputs("done");
        check("done.count", count, 0);
        check("done.error", error, (len == inject));
    endtask

    task automatic start_seq(input bit collide);
        start   = 1'b1;
        wr_en   = collide;
        wr_data = 16'h0BAD;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        bit saw_end;
        reset   = 1'b1;
        wr_data = '0;
        wr_en   = 1'b0;
        start   = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        check("reset.full", full, 0);
        check("reset.count", count, 0);
        check("reset.done", done, 0);
        check("reset.error", error, 0);
        reset = 1'b0;
        tick();

        // Four-sample sequence
        write(16'd5, 1); write(16'd9, 1); write(16'd2, 1); write(16'd7, 1);
        check("w4.count", count, 4);
        start_seq(0);
        observe(-1, 0);
        tick();

        // Single sample: go then finish with the same value
        write(16'd42, 1);
        check("w1.count", count, 1);
        start_seq(0);
        observe(-1, 0);
        tick();

        // Fill to capacity, then overflow
        for (int i = 0; i < 8; i++) write(16'(i * 3 + 100), 1);
        check("fill.count", count, 8);
        check("fill.full", full, 1);
        check("fill.error", error, 0);
        write(16'hFFFF, 0);
        check("ovf.error", error, 1);
        check("ovf.count", count, 8);
        check("ovf.full", full, 1);
        tick();
        check("ovf.error_clear", error, 0);
        start_seq(0);
        observe(-1, 0);
        tick();

        // Start with empty buffer
        start_seq(0);
        check("empty.error", error, 1);
        check_idle_outputs("empty");
        tick();
        check("empty.error_clear", error, 0);
        check("empty.go_late", go, 0);

        // Write while sending body samples is rejected
        for (int i = 0; i < 4; i++) write(16'(20 + i), 1);
        start_seq(0);
        observe(2, 0);
        tick();

        // Reset in the middle of a six-sample sequence
        for (int i = 0; i < 6; i++) write(16'(200 + i), 1);
        start_seq(0);
        check("rst.go", go, 1);
        check("rst.data0", data_out, sb[0]);
        tick();
        check("rst.body_busy", busy, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        check_idle_outputs("rst");
        check("rst.count", count, 0);
        check("rst.done", done, 0);
        check("rst.full", full, 0);
        saw_end = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            saw_end = saw_end | finish | done | go;
        end
        check("rst.no_finish", saw_end, 0);

        // Start and write in the same idle cycle: start wins, write dropped
        for (int i = 0; i < 3; i++) write(16'(50 + i), 1);
        start_seq(1);
        observe(-1, 1);
        tick();

        // Refill and start in the done cycle: go arrives two cycles later
        write(16'd11, 1); write(16'd12, 1); write(16'd13, 1);
        start_seq(0);
        observe(-1, 0);
        wr_en   = 1'b1;
        wr_data = 16'd77;
        start   = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        sb.push_back(16'd77);
        check("b2b.gap_go", go, 0);
        check("b2b.gap_busy", busy, 0);
        check("b2b.gap_count", count, 1);
        check("b2b.gap_error", error, 0);
        tick();
        observe(-1, 0);
        tick();
        check("final.sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
